// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP32 field widths, constants and flag bit positions
package fp_pkg;

   localparam int EXP_W   = 8;
   localparam int FRAC_W  = 23;
   localparam int BIAS    = 127;
   localparam int EXP_MAX = 2 * BIAS + 1;

   localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
   localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;

   // out_flags = {overflow, underflow, inexact, zero}
   localparam int FLAG_OVF  = 3;
   localparam int FLAG_UDF  = 2;
   localparam int FLAG_INX  = 1;
   localparam int FLAG_ZERO = 0;

endpackage

// File: rtl/fp_lzc27.sv
// rtl/fp_lzc27.sv - combinational 27-bit leading-zero counter, 27 for all-zero
module fp_lzc27 (
   input  logic [26:0] data,
   output logic [4:0]  count
);

   // Ascending scan: the last hit is the most significant set bit.
   always_comb begin
      count = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (data[i]) count = 5'(26 - i);
      end
   end

endmodule

// File: rtl/fp_norm_round.sv
// rtl/fp_norm_round.sv - FP32 adder normalise/round-to-nearest-even/pack, 2-stage pipeline
// Optional: FP_FLUSH_TO_ZERO_EN replaces denormal results by signed zero.
module fp_norm_round #(
   parameter int EXP_W  = fp_pkg::EXP_W,
   parameter int FRAC_W = fp_pkg::FRAC_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_sign,
   input  logic [EXP_W-1:0]        in_exp,
   input  logic [FRAC_W+4:0]       in_sum,
   input  logic                    in_sticky,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [EXP_W+FRAC_W:0]   out_result,
   output logic [3:0]              out_flags
);
   import fp_pkg::*;

   localparam int M_W = FRAC_W + 4;
   localparam int P_W = EXP_W + FRAC_W + 1;

   logic              s1_valid, s2_adv;
   logic              s1_sign, s1_zero;
   logic [EXP_W:0]    s1_exp;
   logic [M_W-1:0]    s1_mant;

   logic [M_W:0]      sum_s;
   logic [4:0]        lz;
   logic [EXP_W-1:0]  shift_max, shift_amt;
   logic [M_W-1:0]    n_mant;
   logic [EXP_W:0]    n_exp;

   logic              l_bit, g_bit, rs_bit, inc, inexact;
   logic [FRAC_W+1:0] rnd;
   logic [EXP_W:0]    r_exp;
   logic [P_W-1:0]    r_result;
   logic [3:0]        r_flags;

   assign sum_s = {in_sum[M_W:1], in_sum[0] | in_sticky};

   fp_lzc27 u_lzc (
      .data  (sum_s[M_W-1:0]),
      .count (lz)
   );

   // Left shift is capped so the exponent never drops below 1; a missing hidden bit then marks a denormal.
   always_comb begin
      shift_max = (in_exp == '0) ? '0 : in_exp - EXP_W'(1);
      shift_amt = (EXP_W'(lz) < shift_max) ? EXP_W'(lz) : shift_max;
      if (sum_s[M_W]) begin
         n_mant = {sum_s[M_W:2], sum_s[1] | sum_s[0]};
         n_exp  = {1'b0, in_exp} + (EXP_W+1)'(1);
      end else begin
         n_mant = sum_s[M_W-1:0] << shift_amt;
         n_exp  = {1'b0, in_exp} - {1'b0, shift_amt};
      end
      if (!n_mant[M_W-1]) n_exp = '0;
   end

   always_comb begin
      l_bit   = s1_mant[3];
      g_bit   = s1_mant[2];
      rs_bit  = s1_mant[1] | s1_mant[0];
      inexact = g_bit | rs_bit;
      inc     = g_bit & (rs_bit | l_bit);
      rnd     = {1'b0, s1_mant[M_W-1:3]} + (FRAC_W+2)'(inc);
      // Carry past the hidden bit leaves the fraction at zero by construction.
      if (rnd[FRAC_W+1])
         r_exp = s1_exp + (EXP_W+1)'(1);
      else if (s1_exp == '0 && rnd[FRAC_W])
         r_exp = (EXP_W+1)'(1);
      else
         r_exp = s1_exp;
      r_flags  = '0;
      r_result = {s1_sign, r_exp[EXP_W-1:0], rnd[FRAC_W-1:0]};
      if (s1_zero) begin
         r_result           = {s1_sign, FP32_ZERO[P_W-2:0]};
         r_flags[FLAG_ZERO] = 1'b1;
      end else if (r_exp >= (EXP_W+1)'(EXP_MAX)) begin
         r_result          = {s1_sign, FP32_POS_INF[P_W-2:0]};
         r_flags[FLAG_OVF] = 1'b1;
         r_flags[FLAG_INX] = 1'b1;
      end else begin
         r_flags[FLAG_INX] = inexact;
`ifdef FP_FLUSH_TO_ZERO_EN
         if (r_exp == '0) begin
            r_result           = {s1_sign, FP32_ZERO[P_W-2:0]};
            r_flags[FLAG_UDF]  = 1'b1;
            r_flags[FLAG_INX]  = 1'b1;
            r_flags[FLAG_ZERO] = 1'b1;
         end
`else
         r_flags[FLAG_UDF]  = (r_exp == '0) && inexact;
         r_flags[FLAG_ZERO] = (r_result[P_W-2:0] == '0);
`endif
      end
   end

   assign s2_adv   = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_adv;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_sign    <= 1'b0;
         s1_zero    <= 1'b0;
         s1_exp     <= '0;
         s1_mant    <= '0;
         out_valid  <= 1'b0;
         out_result <= FP32_ZERO[P_W-1:0];
         out_flags  <= '0;
      end else begin
         if (in_ready) s1_valid <= in_valid;
         if (in_valid && in_ready) begin
            s1_sign <= in_sign;
            s1_zero <= (in_sum == '0);
            s1_exp  <= n_exp;
            s1_mant <= n_mant;
         end
         if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_result <= r_result;
               out_flags  <= r_flags;
            end
         end
      end
   end

endmodule
